// File: rtl/huff_merge.sv
// huff_merge: Huffman tree builder fed by the node sorter.
//   Leaves {weight, id} are loaded one per beat into a weight-sorted buffer.
//   The block then repeatedly pops the two lightest entries, emits a merge
//   record {left, right, parent, weight} and re-inserts the parent, until one
//   node remains. That node's id is reported as root_id with a done pulse.
// Ports:
//   CLK, nRST                 clock (rising edge), async active-low reset
//   load_valid/ready/node/last leaf input stream (ready only while idle)
//   merge_valid/ready         merge record handshake
//   merge_left/right/parent   child ids (lighter first) and assigned parent id
//   merge_weight              parent weight, saturated to all-ones
//   done, root_id             tree-complete pulse and root id (held)
//   err                       sticky overflow flag, cleared by a load_last beat
module huff_merge #(
    parameter int MAXN = 8,
    parameter int WW   = 8,
    parameter int IW   = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             load_valid,
    input  logic [WW+IW-1:0] load_node,
    input  logic             load_last,
    output logic             load_ready,
    output logic             merge_valid,
    input  logic             merge_ready,
    output logic [IW-1:0]    merge_left,
    output logic [IW-1:0]    merge_right,
    output logic [IW-1:0]    merge_parent,
    output logic [WW-1:0]    merge_weight,
    output logic             done,
    output logic [IW-1:0]    root_id,
    output logic             err
);

    localparam int CW = $clog2(MAXN + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MERGE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_INSERT = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]                  state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [CW-1:0]               idx_q, idx_d;
    logic [MAXN-1:0][WW-1:0]     bw_q, bw_d;
    logic [MAXN-1:0][IW-1:0]     bid_q, bid_d;
    logic [IW-1:0]               ml_q, ml_d, mr_q, mr_d, mp_q, mp_d;
    logic [WW-1:0]               mw_q, mw_d;
    logic [IW-1:0]               root_q, root_d;
    logic                        err_q, err_d;
    logic                        rdy_q, rdy_d;

    // Sorted insertion of one node: the leaf on the load port while idle,
    // the just-emitted parent while in INSERT.
    logic [WW-1:0]               new_w;
    logic [IW-1:0]               new_id;
    logic [CW-1:0]               pos;
    logic [MAXN-1:0][WW-1:0]     ins_bw;
    logic [MAXN-1:0][IW-1:0]     ins_bid;

    always_comb begin
        if (state_q == S_INSERT) begin
            new_w  = mw_q;
            new_id = mp_q;
        end else begin
            new_w  = load_node[WW+IW-1:IW];
            new_id = load_node[IW-1:0];
        end
        // Strictly-lighter entries stay in front, so the new node lands
        // ahead of any existing entry of equal weight.
        pos = '0;
        for (int i = 0; i < MAXN; i++)
            if (CW'(i) < cnt_q && bw_q[i] < new_w) pos = pos + CW'(1);
        ins_bw  = bw_q;
        ins_bid = bid_q;
        for (int i = 1; i < MAXN; i++)
            if (CW'(i) > pos) begin
                ins_bw[i]  = bw_q[i-1];
                ins_bid[i] = bid_q[i-1];
            end
        for (int i = 0; i < MAXN; i++)
            if (CW'(i) == pos) begin
                ins_bw[i]  = new_w;
                ins_bid[i] = new_id;
            end
    end

    logic [WW:0] sum;
    logic        load_hs, full;

    assign sum     = {1'b0, bw_q[0]} + {1'b0, bw_q[1]};
    assign load_hs = load_valid && rdy_q;
    assign full    = (cnt_q == CW'(MAXN));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bw_d    = bw_q;
        bid_d   = bid_q;
        ml_d    = ml_q;
        mr_d    = mr_q;
        mp_d    = mp_q;
        mw_d    = mw_q;
        root_d  = root_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (load_hs) begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        bw_d  = ins_bw;
                        bid_d = ins_bid;
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (load_last) begin
                        // A dropped last beat still closes the tree, but its
                        // overflow must survive the clear.
                        if (!full) err_d = 1'b0;
                        if (!full && cnt_q == '0) begin
                            state_d = S_DONE;
                            root_d  = ins_bid[0];
                        end else begin
                            state_d = S_MERGE;
                        end
                    end
                end
            end
            S_MERGE: begin
                ml_d = bid_q[0];
                mr_d = bid_q[1];
                mw_d = sum[WW] ? {WW{1'b1}} : sum[WW-1:0];
                mp_d = IW'(16) + IW'(idx_q);
                for (int i = 0; i < MAXN - 2; i++) begin
                    bw_d[i]  = bw_q[i+2];
                    bid_d[i] = bid_q[i+2];
                end
                bw_d[MAXN-1]  = '0;
                bw_d[MAXN-2]  = '0;
                bid_d[MAXN-1] = '0;
                bid_d[MAXN-2] = '0;
                cnt_d   = cnt_q - CW'(2);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (merge_ready) state_d = S_INSERT;
            end
            S_INSERT: begin
                bw_d  = ins_bw;
                bid_d = ins_bid;
                cnt_d = cnt_q + CW'(1);
                idx_d = idx_q + CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    root_d  = ins_bid[0];
                end else begin
                    state_d = S_MERGE;
                end
            end
            S_DONE: begin
                bw_d    = '0;
                bid_d   = '0;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Registered so it stays low through reset and rises on the first edge.
        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bw_q    <= '0;
            bid_q   <= '0;
            ml_q    <= '0;
            mr_q    <= '0;
            mp_q    <= '0;
            mw_q    <= '0;
            root_q  <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bw_q    <= bw_d;
            bid_q   <= bid_d;
            ml_q    <= ml_d;
            mr_q    <= mr_d;
            mp_q    <= mp_d;
            mw_q    <= mw_d;
            root_q  <= root_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    assign load_ready   = rdy_q;
    assign merge_valid  = (state_q == S_WAIT);
    assign merge_left   = ml_q;
    assign merge_right  = mr_q;
    assign merge_parent = mp_q;
    assign merge_weight = mw_q;
    assign done         = (state_q == S_DONE);
    assign root_id      = root_q;
    assign err          = err_q;

endmodule

// File: tb/tb_huff_merge.sv
module tb_huff_merge;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        load_valid = 1'b0;
    logic [12:0] load_node = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        merge_valid;
    logic        merge_ready = 1'b0;
    logic [4:0]  merge_left, merge_right, merge_parent;
    logic [7:0]  merge_weight;
    logic        done;
    logic [4:0]  root_id;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    huff_merge #(.MAXN(8), .WW(8), .IW(5)) dut (
        .CLK(CLK), .nRST(nRST),
        .load_valid(load_valid), .load_node(load_node), .load_last(load_last),
        .load_ready(load_ready),
        .merge_valid(merge_valid), .merge_ready(merge_ready),
        .merge_left(merge_left), .merge_right(merge_right),
        .merge_parent(merge_parent), .merge_weight(merge_weight),
        .done(done), .root_id(root_id), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input int w, input int id, input bit last);
        load_valid = 1'b1;
        load_node  = {w[7:0], id[4:0]};
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Waits for a record, checks latency and fields, holds off for 'hold'
    // cycles checking stability, then optionally accepts it.
    task automatic get_rec(input string tag, input int lat, input int l, input int r,
                           input int p, input int w, input int hold, input bit ack);
        int cyc = 0;
        while (!merge_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!merge_valid) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        if (lat >= 0) chk({tag, "_lat"}, cyc, lat);
        for (int k = 0; k <= hold; k++) begin
            chk({tag, "_vld"}, merge_valid, 1);
            chk({tag, "_L"}, merge_left, l);
            chk({tag, "_R"}, merge_right, r);
            chk({tag, "_P"}, merge_parent, p);
            chk({tag, "_W"}, merge_weight, w);
            if (k < hold) tick();
        end
        if (ack) begin
            merge_ready = 1'b1;
            tick();
            merge_ready = 1'b0;
            chk({tag, "_drop"}, merge_valid, 0);
        end
    endtask

    task automatic wait_done(input string tag, input int lat, input int root);
        int cyc = 0;
        while (!done && cyc < 20) begin
            chk({tag, "_novld"}, merge_valid, 0);
            tick();
            cyc++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_root"}, root_id, root);
        tick();
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_ready"}, load_ready, 1);
        chk({tag, "_root_hold"}, root_id, root);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lr"}, load_ready, 0);
        chk({tag, "_mv"}, merge_valid, 0);
        chk({tag, "_fields"}, {merge_left, merge_right, merge_parent, merge_weight}, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_root"}, root_id, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    int ovl_l[7] = '{7, 5, 3, 1, 19, 17, 21};
    int ovl_r[7] = '{6, 4, 2, 0, 18, 16, 20};
    int ovl_w[7] = '{2, 2, 2, 2, 4, 4, 8};

    initial begin
        // Reset state
        tick();
        tick();
        chk_zero("rst");
        nRST = 1'b1;
        chk("rst_rel_lr", load_ready, 0);
        tick();
        chk("rst_first_lr", load_ready, 1);

        // Basic three-leaf tree
        load(5, 1, 0);
        load(3, 2, 0);
        load(9, 3, 1);
        chk("basic_lr_low", load_ready, 0);
        get_rec("basic1", 1, 2, 1, 16, 8, 0, 1);
        get_rec("basic2", 2, 16, 3, 17, 17, 0, 1);
        wait_done("basic", 1, 17);

        // Ties: newer equal-weight entry sorts first
        load(2, 0, 0);
        load(2, 1, 0);
        load(4, 2, 1);
        get_rec("tie1", 1, 1, 0, 16, 4, 0, 1);
        get_rec("tie2", 2, 16, 2, 17, 8, 0, 1);
        wait_done("tie", 1, 17);

        // Weight saturation
        load(200, 4, 0);
        load(100, 5, 1);
        get_rec("sat", 1, 5, 4, 16, 255, 0, 1);
        wait_done("sat", 1, 16);
        chk("sat_err", err, 0);

        // Single leaf: no record, done next cycle
        load(7, 9, 1);
        wait_done("single", 0, 9);

        // Backpressure: record held stable for 5 stalled cycles
        load(5, 1, 0);
        load(3, 2, 0);
        load(9, 3, 1);
        get_rec("bp1", 1, 2, 1, 16, 8, 5, 1);
        get_rec("bp2", 2, 16, 3, 17, 17, 0, 1);
        wait_done("bp", 1, 17);

        // Overflow: 9 leaves into an 8-deep buffer, last beat dropped
        for (int i = 0; i < 9; i++) begin
            chk("ovl_lr", load_ready, 1);
            load(1, i, i == 8);
        end
        chk("ovl_err", err, 1);
        for (int k = 0; k < 7; k++)
            get_rec($sformatf("ovl%0d", k + 1), (k == 0) ? 1 : 2,
                    ovl_l[k], ovl_r[k], 16 + k, ovl_w[k], 0, k < 6);
        chk("ovl_err_hold", err, 1);

        // Async reset while the last record is waiting
        nRST = 1'b0;
        #1;
        chk_zero("midrst");
        #2;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        chk("midrst_lr", load_ready, 1);
        chk("midrst_mv", merge_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
